// File: rtl/lcd_transaction_ctrl.sv
// lcd_transaction_ctrl: HD44780 transaction layer that runs the configuration sequence, full-frame refreshes and single-character writes over a start/done phy handshake.
// Ports: clk/reset (sync, active-high); phy_init_done/phy_done in, phy_start/phy_rs/phy_data out to the 4-bit phy;
//        do_write_frame + frame_data, do_write_char + char_row/char_col/char_data requests in;
//        init_complete, busy, frame_done, char_done status out.
module lcd_transaction_ctrl #(
  parameter int          ROWS       = 2,
  parameter int          COLS       = 16,
  parameter logic [31:0] ROW_BASES  = 32'h54144000,
  parameter int          CMD_WAIT   = 2000,
  parameter int          CLEAR_WAIT = 82000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   phy_init_done,
  input  logic                   phy_done,
  output logic                   phy_start,
  output logic                   phy_rs,
  output logic [7:0]             phy_data,
  input  logic                   do_write_frame,
  input  logic [ROWS*COLS*8-1:0] frame_data,
  input  logic                   do_write_char,
  input  logic [1:0]             char_row,
  input  logic [5:0]             char_col,
  input  logic [7:0]             char_data,
  output logic                   init_complete,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   char_done
);
  localparam int CW = $clog2((CLEAR_WAIT > CMD_WAIT ? CLEAR_WAIT : CMD_WAIT) + 1);
  typedef enum logic [2:0] {INIT_WAIT, SEND, WAIT_DONE, GAP, IDLE, CHAR_OOR} state_t;
  typedef enum logic [1:0] {OP_INIT, OP_FRAME, OP_CHAR} op_t;
  state_t                 r_state, w_next;
  op_t                    r_op;
  logic [1:0]             r_idx, r_row;
  logic [5:0]             r_col;
  logic                   r_addr;
  logic [CW-1:0]          r_cnt;
  logic [ROWS*COLS*8-1:0] r_frame;
  logic [7:0]             r_cdata;
  logic                   r_init_complete, r_frame_done, r_char_done;
  logic [6:0]             w_base;
  logic [7:0]             w_fidx, w_byte;
  logic                   w_rs, w_xfer, w_gap_last, w_last_col, w_last_row, w_done_seq, w_oor;
  assign w_base     = ROW_BASES[{r_row, 3'b000} +: 7];
  assign w_fidx     = 8'(r_row) * 8'(COLS) + 8'(r_col);
  // r_addr marks the SET_ADDR instruction that precedes the data bytes of a row or single write
  assign w_byte     = r_op == OP_INIT ? (r_idx == 2'd0 ? 8'h28 : r_idx == 2'd1 ? 8'h06 : r_idx == 2'd2 ? 8'h0C : 8'h01) :
                      r_addr ? {1'b1, r_op == OP_CHAR ? w_base + {1'b0, r_col} : w_base} :
                      r_op == OP_CHAR ? r_cdata : r_frame[{w_fidx, 3'b000} +: 8];
  assign w_rs       = r_op != OP_INIT && !r_addr;
  assign w_gap_last = r_cnt == ((r_op == OP_INIT && r_idx == 2'd3) ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1));
  assign w_last_col = r_col == 6'(COLS - 1);
  assign w_last_row = r_row == 2'(ROWS - 1);
  assign w_done_seq = r_op == OP_INIT ? r_idx == 2'd3 : r_op == OP_CHAR ? !r_addr : !r_addr && w_last_col && w_last_row;
  assign w_oor      = {1'b0, char_row} >= 3'(ROWS) || {1'b0, char_col} >= 7'(COLS);
  assign w_xfer     = r_state == SEND || r_state == WAIT_DONE;
  assign phy_start  = r_state == SEND;
  assign phy_rs     = w_xfer && w_rs;
  assign phy_data   = w_xfer ? w_byte : 8'h00;
  assign busy       = r_state != IDLE;
  assign init_complete = r_init_complete;
  assign frame_done = r_frame_done;
  assign char_done  = r_char_done;
  always_ff @(posedge clk)
    r_state <= reset ? INIT_WAIT : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT_WAIT: w_next = phy_init_done ? SEND : INIT_WAIT;
      SEND:      w_next = WAIT_DONE;
      WAIT_DONE: w_next = phy_done ? GAP : WAIT_DONE;
      GAP:       w_next = w_gap_last ? (w_done_seq ? IDLE : SEND) : GAP;
      IDLE:      w_next = (do_write_frame || (do_write_char && !w_oor)) ? SEND : do_write_char ? CHAR_OOR : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op            <= OP_INIT;
      r_idx           <= '0;
      r_row           <= '0;
      r_col           <= '0;
      r_addr          <= 1'b0;
      r_cnt           <= '0;
      r_frame         <= '0;
      r_cdata         <= '0;
      r_init_complete <= 1'b0;
      r_frame_done    <= 1'b0;
      r_char_done     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_char_done  <= 1'b0;
      r_cnt        <= (r_state == GAP && !w_gap_last) ? r_cnt + 1'b1 : '0;
      if (r_state == GAP && w_gap_last) begin
        if (w_done_seq) begin
          r_init_complete <= r_init_complete || r_op == OP_INIT;
          r_frame_done    <= r_op == OP_FRAME;
          r_char_done     <= r_op == OP_CHAR;
          r_row           <= '0;
          r_col           <= '0;
        end else if (r_op == OP_INIT)
          r_idx <= r_idx + 2'd1;
        else if (r_addr)
          r_addr <= 1'b0;
        else begin
          r_col  <= w_last_col ? '0 : r_col + 6'd1;
          r_row  <= w_last_col ? r_row + 2'd1 : r_row;
          r_addr <= w_last_col;
        end
      end
      if (r_state == IDLE && do_write_frame) begin
        r_op    <= OP_FRAME;
        r_frame <= frame_data;
        r_row   <= '0;
        r_col   <= '0;
        r_addr  <= 1'b1;
      end else if (r_state == IDLE && do_write_char) begin
        r_op        <= OP_CHAR;
        r_row       <= char_row;
        r_col       <= char_col;
        r_cdata     <= char_data;
        r_addr      <= 1'b1;
        // out-of-range coordinates complete immediately without touching the phy
        r_char_done <= w_oor;
      end
    end
  end
endmodule

// File: tb/tb_lcd_transaction_ctrl.sv
// tb_lcd_transaction_ctrl: directed self-checking bench for lcd_transaction_ctrl with a small auto-acking phy model.
module tb_lcd_transaction_ctrl;
  localparam int ROWS = 2;
  localparam int COLS = 4;
  logic clk = 1'b0, reset = 1'b1, phy_init_done = 1'b0, phy_done = 1'b0;
  logic do_write_frame = 1'b0, do_write_char = 1'b0;
  logic [1:0] char_row = '0;
  logic [5:0] char_col = '0;
  logic [7:0] char_data = '0;
  logic [ROWS*COLS*8-1:0] frame_data = '0;
  logic phy_start, phy_rs, init_complete, busy, frame_done, char_done;
  logic [7:0] phy_data;
  int cyc = 0, n_checks = 0, n_fail = 0, n_fd = 0, n_cd = 0;
  logic [8:0] q_b[$];
  int q_c[$];
  lcd_transaction_ctrl #(.ROWS(ROWS), .COLS(COLS), .ROW_BASES(32'h54144000), .CMD_WAIT(4), .CLEAR_WAIT(10)) dut (
    .clk(clk), .reset(reset), .phy_init_done(phy_init_done), .phy_done(phy_done),
    .phy_start(phy_start), .phy_rs(phy_rs), .phy_data(phy_data),
    .do_write_frame(do_write_frame), .frame_data(frame_data),
    .do_write_char(do_write_char), .char_row(char_row), .char_col(char_col), .char_data(char_data),
    .init_complete(init_complete), .busy(busy), .frame_done(frame_done), .char_done(char_done));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (phy_start) begin
      q_b.push_back({phy_rs, phy_data});
      q_c.push_back(cyc);
    end
    if (frame_done) n_fd++;
    if (char_done) n_cd++;
  end
  // phy model: phy_done high during the third cycle after each start
  initial forever begin
    @(negedge clk);
    if (phy_start) begin
      repeat (3) @(negedge clk);
      phy_done = 1'b1;
      @(negedge clk);
      phy_done = 1'b0;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic wait_init(input string name);
    int i;
    for (i = 0; i < 300 && !init_complete; i++) tick();
    n_checks++;
    if (init_complete !== 1'b1) begin
      n_fail++;
      $display("FAIL %s init_complete timeout: got %b want 1", name, init_complete);
    end
  endtask
  task automatic wait_frame_done(input int base, input string name);
    int i;
    for (i = 0; i < 400 && n_fd == base; i++) tick();
    n_checks++;
    if (n_fd !== base + 1) begin
      n_fail++;
      $display("FAIL %s frame_done count: got %0d want %0d", name, n_fd, base + 1);
    end
  endtask
  task automatic test_reset;
    tick(3);
    n_checks++;
    if ({phy_start, phy_rs, phy_data} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_phy: got start=%b rs=%b data=%h want 0 0 00", phy_start, phy_rs, phy_data);
    end
    n_checks++;
    if ({init_complete, busy, frame_done, char_done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_status: got ic/busy/fd/cd=%b want 0100", {init_complete, busy, frame_done, char_done});
    end
  endtask
  task automatic test_init;
    logic prev_busy;
    logic [8:0] exp [4] = '{9'h028, 9'h006, 9'h00C, 9'h001};
    reset = 1'b0;
    tick(20);
    n_checks++;
    if (q_b.size() !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL init_wait_idle: got starts=%0d busy=%b want 0 1", q_b.size(), busy);
    end
    phy_init_done = 1'b1;
    prev_busy = busy;
    for (int i = 0; i < 300 && !init_complete; i++) begin
      prev_busy = busy;
      tick();
    end
    n_checks++;
    if ({prev_busy, init_complete, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL init_edge: got prev_busy/ic/busy=%b want 110", {prev_busy, init_complete, busy});
    end
    n_checks++;
    if (q_b.size() !== 4) begin
      n_fail++;
      $display("FAIL init_count: got %0d want 4", q_b.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q_b[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL init_byte%0d: got %h want %h", i, q_b[i], exp[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (q_c[i] - q_c[i-1] !== 8) begin
          n_fail++;
          $display("FAIL init_spacing%0d: got %0d want 8", i, q_c[i] - q_c[i-1]);
        end
      end
      n_checks++;
      if (cyc - q_c[3] !== 14) begin
        n_fail++;
        $display("FAIL clear_gap: got %0d want 14", cyc - q_c[3]);
      end
    end
  endtask
  task automatic test_frame;
    int base = n_fd;
    logic [8:0] exp [10] = '{9'h080, 9'h141, 9'h142, 9'h143, 9'h144, 9'h0C0, 9'h145, 9'h146, 9'h147, 9'h148};
    q_b.delete();
    q_c.delete();
    frame_data = "HGFEDCBA";
    do_write_frame = 1'b1;
    tick();
    do_write_frame = 1'b0;
    frame_data = "zzzzzzzz";
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_busy_rise: got %b want 1", busy);
    end
    wait_frame_done(base, "frame");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_busy_end: got %b want 0", busy);
    end
    tick(10);
    n_checks++;
    if (q_b.size() !== 10 || n_fd !== base + 1) begin
      n_fail++;
      $display("FAIL frame_count: got bytes=%0d done=%0d want 10 %0d", q_b.size(), n_fd, base + 1);
    end else
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (q_b[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL frame_byte%0d: got %h want %h", i, q_b[i], exp[i]);
        end
      end
    frame_data = "HGFEDCBA";
  endtask
  task automatic test_char;
    int base = n_cd;
    q_b.delete();
    char_row = 2'd1;
    char_col = 6'd3;
    char_data = "Z";
    do_write_char = 1'b1;
    tick();
    do_write_char = 1'b0;
    char_data = 8'h00;
    for (int i = 0; i < 100 && n_cd == base; i++) tick();
    tick(5);
    n_checks++;
    if (q_b.size() !== 2 || n_cd !== base + 1) begin
      n_fail++;
      $display("FAIL char_count: got bytes=%0d done=%0d want 2 %0d", q_b.size(), n_cd, base + 1);
    end else begin
      n_checks++;
      if (q_b[0] !== 9'h0C3) begin
        n_fail++;
        $display("FAIL char_addr: got %h want 0c3", q_b[0]);
      end
      n_checks++;
      if (q_b[1] !== 9'h15A) begin
        n_fail++;
        $display("FAIL char_data: got %h want 15a", q_b[1]);
      end
    end
  endtask
  task automatic test_out_of_range(input logic [1:0] row, input logic [5:0] col, input string name);
    int base = n_cd;
    q_b.delete();
    char_row = row;
    char_col = col;
    char_data = "Q";
    do_write_char = 1'b1;
    tick();
    do_write_char = 1'b0;
    n_checks++;
    if ({char_done, busy, phy_start} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s accept: got cd/busy/start=%b want 110", name, {char_done, busy, phy_start});
    end
    tick(20);
    n_checks++;
    if (q_b.size() !== 0 || n_cd !== base + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after: got starts=%0d done=%0d busy=%b want 0 %0d 0", name, q_b.size(), n_cd, busy, base + 1);
    end
  endtask
  task automatic test_collision;
    int bf = n_fd, bc = n_cd;
    q_b.delete();
    char_row = 2'd0;
    char_col = 6'd0;
    char_data = "Q";
    do_write_frame = 1'b1;
    do_write_char = 1'b1;
    tick();
    do_write_frame = 1'b0;
    do_write_char = 1'b0;
    for (int i = 0; i < 100 && q_b.size() < 3; i++) tick();
    char_col = 6'd1;
    do_write_char = 1'b1;
    tick();
    do_write_char = 1'b0;
    wait_frame_done(bf, "collision");
    tick(30);
    n_checks++;
    if (q_b.size() !== 10 || n_cd !== bc) begin
      n_fail++;
      $display("FAIL collision_count: got starts=%0d char_done=%0d want 10 %0d", q_b.size(), n_cd, bc);
    end else begin
      n_checks++;
      if (q_b[1] !== 9'h141 || q_b[9] !== 9'h148) begin
        n_fail++;
        $display("FAIL collision_bytes: got %h %h want 141 148", q_b[1], q_b[9]);
      end
    end
  endtask
  task automatic test_mid_reset;
    int bf = n_fd;
    q_b.delete();
    do_write_frame = 1'b1;
    tick();
    do_write_frame = 1'b0;
    for (int i = 0; i < 200 && q_b.size() < 5; i++) tick();
    reset = 1'b1;
    phy_init_done = 1'b0;
    tick();
    n_checks++;
    if ({phy_start, phy_rs, phy_data, init_complete, busy, frame_done, char_done} !== 14'b00_00000000_0100) begin
      n_fail++;
      $display("FAIL midreset_outputs: got start=%b rs=%b data=%h ic=%b busy=%b fd=%b cd=%b want 0 0 00 0 1 0 0",
               phy_start, phy_rs, phy_data, init_complete, busy, frame_done, char_done);
    end
    tick();
    reset = 1'b0;
    q_b.delete();
    tick(5);
    phy_init_done = 1'b1;
    wait_init("midreset");
    tick(5);
    n_checks++;
    if (q_b.size() !== 4 || n_fd !== bf) begin
      n_fail++;
      $display("FAIL midreset_count: got bytes=%0d frame_done=%0d want 4 %0d", q_b.size(), n_fd, bf);
    end else begin
      n_checks++;
      if (q_b[0] !== 9'h028 || q_b[3] !== 9'h001) begin
        n_fail++;
        $display("FAIL midreset_bytes: got %h %h want 028 001", q_b[0], q_b[3]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_init();
    test_frame();
    test_char();
    test_out_of_range(2'd2, 6'd0, "oor_row");
    test_out_of_range(2'd0, 6'd4, "oor_col");
    test_collision();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
